// File: rtl/bird_ctrl.sv
// bird_ctrl: game-control front end for the bird FSM.
// Synchronises and debounces the player keys, turns presses into single-cycle
// command pulses, runs the IDLE/PLAYING/DEAD game FSM, gates collision hits
// into kill, and keeps the current and best scores in BCD.
// Optional feature: define BIRD_CTRL_AUTOREPEAT_EN to re-pulse jump while the
// jump key is held in PLAYING.
module bird_ctrl #(
    parameter int unsigned DEBOUNCE_TICKS   = 3,
    parameter int unsigned GRACE_TICKS      = 100,
    parameter int unsigned DEATH_HOLD_TICKS = 200,
    parameter int unsigned REPEAT_TICKS     = 25
) (
    input  logic        clk_100Hz,
    input  logic        rst,
    input  logic        key_start,
    input  logic        key_jump,
    input  logic        key_fall,
    input  logic        key_reset,
    input  logic        hit,
    output logic        start,
    output logic        jump,
    output logic        fall,
    output logic        kill,
    output logic        game_rst,
    output logic [1:0]  game_state,
    output logic [15:0] score_bcd,
    output logic [15:0] best_bcd,
    output logic        new_best
);

    localparam int unsigned KStart = 0;
    localparam int unsigned KJump  = 1;
    localparam int unsigned KFall  = 2;
    localparam int unsigned KReset = 3;

    localparam int unsigned GraceW = (GRACE_TICKS > 0) ? $clog2(GRACE_TICKS + 1) : 1;
    localparam int unsigned HoldW  = (DEATH_HOLD_TICKS > 0) ? $clog2(DEATH_HOLD_TICKS + 1) : 1;
    localparam logic [3:0]  DebLast = 4'(DEBOUNCE_TICKS - 1);

    // Parameter sanity checks at elaboration
    if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15) begin : g_deb_chk
        $error("DEBOUNCE_TICKS must be in 1..15");
    end
    if (REPEAT_TICKS < 1) begin : g_rep_chk
        $error("REPEAT_TICKS must be at least 1");
    end

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPlaying = 2'd1,
        StDead    = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Key synchronisation and debounce
    // ------------------------------------------------------------------
    logic [3:0] keys_raw;
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] lvl_q, lvl_d, prev_q;
    logic [3:0] deb_cnt_q [4];
    logic [3:0] deb_cnt_d [4];
    logic [3:0] key_edge;

    assign keys_raw = {key_reset, key_fall, key_jump, key_start};
    assign key_edge = lvl_q & ~prev_q;

    // Debounce: a level changes only after DEBOUNCE_TICKS consecutive differing samples
    always_comb begin
        lvl_d = lvl_q;
        for (int k = 0; k < 4; k++) begin
            deb_cnt_d[k] = '0;
            if (sync2_q[k] != lvl_q[k]) begin
                if (deb_cnt_q[k] == DebLast) begin
                    lvl_d[k] = sync2_q[k];
                end else begin
                    deb_cnt_d[k] = deb_cnt_q[k] + 4'd1;
                end
            end
        end
    end

    // Synchroniser, debounce and previous-level registers
    always_ff @(posedge clk_100Hz) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            prev_q  <= '0;
            for (int k = 0; k < 4; k++) deb_cnt_q[k] <= '0;
        end else begin
            sync1_q <= keys_raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            prev_q  <= lvl_q;
            for (int k = 0; k < 4; k++) deb_cnt_q[k] <= deb_cnt_d[k];
        end
    end

    // ------------------------------------------------------------------
    // Game FSM, counters and scores
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic                start_q, start_d, jump_q, jump_d, fall_q, fall_d;
    logic                kill_q, kill_d, grst_q, grst_d;
    logic [15:0]         score_q, score_d, best_q, best_d;
    logic                new_best_q, new_best_d;
    logic [GraceW-1:0]   grace_q, grace_d;
    logic [HoldW-1:0]    hold_q, hold_d;
    logic [6:0]          presc_q, presc_d;
    logic                rep_fire;

    // BCD increment with inter-digit carry, saturating at 9999
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        if (v == 16'h9999) return v;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

`ifdef BIRD_CTRL_AUTOREPEAT_EN
    localparam int unsigned RepW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
    logic [RepW-1:0] rep_q, rep_d;

    assign rep_fire = lvl_q[KJump] && (rep_q == RepW'(REPEAT_TICKS));

    // Repeat counter: restarts at each jump pulse, clears on release or state change
    always_comb begin
        rep_d = '0;
        if (state_q == StPlaying && state_d == StPlaying) begin
            if (jump_d) begin
                rep_d = RepW'(1);
            end else if (lvl_q[KJump] && rep_q != '0) begin
                rep_d = rep_q + RepW'(1);
            end
        end
    end

    // Repeat counter register
    always_ff @(posedge clk_100Hz) begin
        if (rst) rep_q <= '0;
        else     rep_q <= rep_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Next-state, pulse and counter logic
    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        jump_d     = 1'b0;
        fall_d     = 1'b0;
        kill_d     = 1'b0;
        grst_d     = 1'b0;
        score_d    = score_q;
        best_d     = best_q;
        new_best_d = new_best_q;
        grace_d    = grace_q;
        hold_d     = hold_q;
        presc_d    = presc_q;

        case (state_q)
            StIdle: begin
                if (key_edge[KStart]) begin
                    start_d = 1'b1;
                    score_d = '0;
                    presc_d = '0;
                    grace_d = GraceW'(GRACE_TICKS);
                    state_d = StPlaying;
                end else if (key_edge[KReset]) begin
                    grst_d = 1'b1;
                end
            end
            StPlaying: begin
                if (grace_q != '0) grace_d = grace_q - GraceW'(1);
                if (key_edge[KReset]) begin
                    grst_d  = 1'b1;
                    state_d = StIdle;
                end else if (hit && grace_q == '0) begin
                    kill_d  = 1'b1;
                    hold_d  = HoldW'(DEATH_HOLD_TICKS);
                    state_d = StDead;
                    // Score is frozen on this edge, so compare the final value
                    if (score_q > best_q) begin
                        best_d     = score_q;
                        new_best_d = 1'b1;
                    end
                end else begin
                    if (presc_q == 7'd99) begin
                        presc_d = '0;
                        score_d = bcd_inc(score_q);
                    end else begin
                        presc_d = presc_q + 7'd1;
                    end
                    if (key_edge[KJump] || rep_fire) begin
                        jump_d = 1'b1;
                    end else if (key_edge[KFall]) begin
                        fall_d = 1'b1;
                    end
                end
            end
            StDead: begin
                if (hold_q != '0) hold_d = hold_q - HoldW'(1);
                if (key_edge[KReset] || (key_edge[KStart] && hold_q == '0)) begin
                    grst_d     = 1'b1;
                    new_best_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, pulse, counter and score registers
    always_ff @(posedge clk_100Hz) begin
        if (rst) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            jump_q     <= 1'b0;
            fall_q     <= 1'b0;
            kill_q     <= 1'b0;
            grst_q     <= 1'b0;
            score_q    <= '0;
            best_q     <= '0;
            new_best_q <= 1'b0;
            grace_q    <= '0;
            hold_q     <= '0;
            presc_q    <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            jump_q     <= jump_d;
            fall_q     <= fall_d;
            kill_q     <= kill_d;
            grst_q     <= grst_d;
            score_q    <= score_d;
            best_q     <= best_d;
            new_best_q <= new_best_d;
            grace_q    <= grace_d;
            hold_q     <= hold_d;
            presc_q    <= presc_d;
        end
    end

    assign start      = start_q;
    assign jump       = jump_q;
    assign fall       = fall_q;
    assign kill       = kill_q;
    assign game_rst   = grst_q;
    assign game_state = state_q;
    assign score_bcd  = score_q;
    assign best_bcd   = best_q;
    assign new_best   = new_best_q;

endmodule
